aes_key_schedule: RTL and testbench



---
 rtl/aes_key_schedule_if.sv | 22 ++
 rtl/aes_key_schedule.sv | 180 ++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_if.sv
// Round-key stream between the AES-128 key schedule (master) and the cipher
// controller / AddRoundKey stage (slave).
interface aes_key_schedule_if;
    logic                    load;
    logic [0:3][0:3][7:0]    key_in;
    logic [0:3][0:3][7:0]    rk;
    logic [3:0]              rk_round;
    logic                    rk_valid;
    logic                    rk_ready;
    logic                    busy;
    logic                    done;

    modport master (
        input  load, key_in, rk_ready,
        output rk, rk_round, rk_valid, busy, done
    );

    modport slave (
        output load, key_in, rk_ready,
        input  rk, rk_round, rk_valid, busy, done
    );
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key (0..10) per accepted handshake.
// Optional macro KEY_SCHED_STORE_EN adds an 11-entry round-key store for decryption.
module aes_key_schedule (
    input  logic                  clk,
    input  logic                  rst,
    aes_key_schedule_if.master    ks
`ifdef KEY_SCHED_STORE_EN
    ,
    input  logic [3:0]            rd_idx,
    output logic [0:3][0:3][7:0]  rd_key,
    output logic                  keys_ready
`endif
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] val;
        case (idx)
            4'd1:    val = 8'h01;
            4'd2:    val = 8'h02;
            4'd3:    val = 8'h04;
            4'd4:    val = 8'h08;
            4'd5:    val = 8'h10;
            4'd6:    val = 8'h20;
            4'd7:    val = 8'h40;
            4'd8:    val = 8'h80;
            4'd9:    val = 8'h1b;
            4'd10:   val = 8'h36;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    state_t                state_r;
    logic [0:3][0:3][7:0]  rk_r;
    logic [3:0]            rk_round_r;
    logic                  rk_valid_r;
    logic                  busy_r;
    logic                  done_r;

    logic [31:0]           w0_s, w1_s, w2_s, w3_s, t_s, n0_s, n1_s, n2_s, n3_s;
    logic [0:3][0:3][7:0]  next_rk_s;
    logic                  xfer_s;
    logic                  last_s;

    assign ks.rk       = rk_r;
    assign ks.rk_round = rk_round_r;
    assign ks.rk_valid = rk_valid_r;
    assign ks.busy     = busy_r;
    assign ks.done     = done_r;

    // Next round key: columns as 32-bit words, RotWord+SubWord+Rcon on w3, then XOR chain.
    always_comb begin
        w0_s = {rk_r[0][0], rk_r[1][0], rk_r[2][0], rk_r[3][0]};
        w1_s = {rk_r[0][1], rk_r[1][1], rk_r[2][1], rk_r[3][1]};
        w2_s = {rk_r[0][2], rk_r[1][2], rk_r[2][2], rk_r[3][2]};
        w3_s = {rk_r[0][3], rk_r[1][3], rk_r[2][3], rk_r[3][3]};
        t_s  = {sbox(w3_s[23:16]), sbox(w3_s[15:8]), sbox(w3_s[7:0]), sbox(w3_s[31:24])}
             ^ {rcon(rk_round_r + 4'd1), 24'h000000};
        n0_s = w0_s ^ t_s;
        n1_s = w1_s ^ n0_s;
        n2_s = w2_s ^ n1_s;
        n3_s = w3_s ^ n2_s;
        next_rk_s = {n0_s[31:24], n1_s[31:24], n2_s[31:24], n3_s[31:24],
                     n0_s[23:16], n1_s[23:16], n2_s[23:16], n3_s[23:16],
                     n0_s[15:8],  n1_s[15:8],  n2_s[15:8],  n3_s[15:8],
                     n0_s[7:0],   n1_s[7:0],   n2_s[7:0],   n3_s[7:0]};
    end

    assign xfer_s = rk_valid_r & ks.rk_ready;
    assign last_s = (rk_round_r == 4'd10);

    // Streaming FSM; load overrides any state, rst overrides load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            rk_r       <= '0;
            rk_round_r <= 4'd0;
            rk_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (ks.load) begin
            state_r    <= EMIT;
            rk_r       <= ks.key_in;
            rk_round_r <= 4'd0;
            rk_valid_r <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rk_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
                EMIT: begin
                    done_r <= 1'b0;
                    if (xfer_s) begin
                        if (last_s) begin
                            state_r    <= IDLE;
                            rk_valid_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            rk_r       <= next_rk_s;
                            rk_round_r <= rk_round_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    rk_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEY_SCHED_STORE_EN
    logic [0:3][0:3][7:0]  store_r [0:10];
    logic                  keys_ready_r;

    assign keys_ready = keys_ready_r;

    // Capture each round key on the same edge that first presents it on rk.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                store_r[i] <= '0;
            end
            keys_ready_r <= 1'b0;
        end else if (ks.load) begin
            store_r[0]   <= ks.key_in;
            keys_ready_r <= 1'b0;
        end else if ((state_r == EMIT) && xfer_s && !last_s) begin
            store_r[rk_round_r + 4'd1] <= next_rk_s;
        end else if ((state_r == EMIT) && xfer_s && last_s) begin
            keys_ready_r <= 1'b1;
        end else begin
            keys_ready_r <= keys_ready_r;
        end
    end

    // Random-access read port; out-of-range indices read as zero.
    always_comb begin
        rd_key = '0;
        if (rd_idx <= 4'd10) begin
            rd_key = store_r[rd_idx];
        end else begin
            rd_key = '0;
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a FIPS-197 word-level model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_schedule;

    typedef logic [0:3][0:3][7:0] mat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    aes_key_schedule_if ks_if();

`ifdef KEY_SCHED_STORE_EN
    logic [3:0] rd_idx = 4'd0;
    mat_t       rd_key;
    logic       keys_ready;
`endif

    aes_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks_if)
`ifdef KEY_SCHED_STORE_EN
        ,
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .keys_ready (keys_ready)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ks_if.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    logic [7:0]   sb [0:255];
    logic [127:0] model_rk [0:10];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int u = 1; u < 256; u++) begin
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            end
            sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]} ^ {rc, 24'h000000};
                rc   = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int k = 0; k < 11; k++) model_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic mat_t to_mat(input logic [127:0] h);
        mat_t m;
        for (int n = 0; n < 16; n++) m[n % 4][n / 4] = h[127 - 8*n -: 8];
        return m;
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; ks_if.load = 1'b0; ks_if.rk_ready = 1'b0; ks_if.key_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ks_if.rk !== mat_t'(0) || ks_if.rk_round !== 4'd0 || ks_if.rk_valid !== 1'b0 ||
            ks_if.busy !== 1'b0 || ks_if.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: rk=%h round=%0d valid=%b busy=%b done=%b, required all zero",
                     ks_if.rk, ks_if.rk_round, ks_if.rk_valid, ks_if.busy, ks_if.done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips();
        int d0;
        compute_model(FIPS_KEY);
        d0 = done_cnt;
        ks_if.rk_ready = 1'b1; ks_if.key_in = to_mat(FIPS_KEY); ks_if.load = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            ks_if.load = 1'b0;
            checks++;
            if (ks_if.rk_valid !== 1'b1 || ks_if.busy !== 1'b1 || ks_if.done !== 1'b0 ||
                ks_if.rk_round !== 4'(i) || ks_if.rk !== to_mat(model_rk[i])) begin
                errors++;
                $display("FAIL fips_round%0d: valid=%b busy=%b done=%b round=%0d rk=%h, required 1 1 0 %0d %h",
                         i, ks_if.rk_valid, ks_if.busy, ks_if.done, ks_if.rk_round, ks_if.rk, i, to_mat(model_rk[i]));
            end
            if (i == 1 || i == 10) begin
                checks++;
                if (ks_if.rk !== to_mat(i == 1 ? FIPS_R1 : FIPS_R10)) begin
                    errors++;
                    $display("FAIL fips_kat%0d: rk=%h required %h", i, ks_if.rk, to_mat(i == 1 ? FIPS_R1 : FIPS_R10));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (ks_if.done !== 1'b1 || ks_if.busy !== 1'b0 || ks_if.rk_valid !== 1'b0 ||
            ks_if.rk_round !== 4'd10 || ks_if.rk !== to_mat(FIPS_R10)) begin
            errors++;
            $display("FAIL fips_done: done=%b busy=%b valid=%b round=%0d rk=%h, required 1 0 0 10 %h",
                     ks_if.done, ks_if.busy, ks_if.rk_valid, ks_if.rk_round, ks_if.rk, to_mat(FIPS_R10));
        end
        @(negedge clk);
        checks++;
        if (ks_if.done !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL fips_done_once: done=%b pulses=%0d, required 0 and 1", ks_if.done, done_cnt - d0);
        end
    endtask

    task automatic test_idle_hold();
        int d0;
        d0 = done_cnt;
        ks_if.rk_ready = 1'b1; ks_if.load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (ks_if.rk_valid !== 1'b0 || ks_if.busy !== 1'b0 || ks_if.done !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold%0d: valid=%b busy=%b done=%b, required 0 0 0",
                         i, ks_if.rk_valid, ks_if.busy, ks_if.done);
            end
        end
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL idle_done_cnt: pulses=%0d required 0", done_cnt - d0);
        end
    endtask

`ifdef KEY_SCHED_STORE_EN
    task automatic test_store();
        compute_model(FIPS_KEY);
        checks++;
        if (keys_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_keys_ready: got %b required 1", keys_ready);
        end
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            #1;
            checks++;
            if (rd_key !== to_mat(model_rk[i])) begin
                errors++;
                $display("FAIL store_rd%0d: got %h required %h", i, rd_key, to_mat(model_rk[i]));
            end
        end
        rd_idx = 4'd10; #1;
        checks++;
        if (rd_key !== to_mat(FIPS_R10)) begin
            errors++;
            $display("FAIL store_rd10_kat: got %h required %h", rd_key, to_mat(FIPS_R10));
        end
        rd_idx = 4'd15; #1;
        checks++;
        if (rd_key !== mat_t'(0)) begin
            errors++;
            $display("FAIL store_rd15: got %h required 0", rd_key);
        end
        @(negedge clk);
        ks_if.rk_ready = 1'b1; ks_if.key_in = to_mat(rand_key()); ks_if.load = 1'b1;
        @(negedge clk);
        ks_if.load = 1'b0;
        checks++;
        if (keys_ready !== 1'b0) begin
            errors++;
            $display("FAIL store_clear: keys_ready=%b required 0", keys_ready);
        end
        repeat (13) @(negedge clk);
        checks++;
        if (keys_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_reready: keys_ready=%b required 1", keys_ready);
        end
    endtask
`endif

    task automatic test_backpressure(input logic [127:0] key);
        int  idx, cyc, d0;
        bit  finished;
        compute_model(key);
        d0 = done_cnt; idx = 0; cyc = 0; finished = 1'b0;
        ks_if.rk_ready = 1'b0; ks_if.key_in = to_mat(key); ks_if.load = 1'b1;
        @(negedge clk);
        ks_if.load = 1'b0;
        while (!finished && cyc < 400) begin
            checks++;
            if (ks_if.rk_valid !== 1'b1 || ks_if.rk_round !== 4'(idx) || ks_if.rk !== to_mat(model_rk[idx])) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b round=%0d rk=%h, required 1 %0d %h",
                         cyc, ks_if.rk_valid, ks_if.rk_round, ks_if.rk, idx, to_mat(model_rk[idx]));
            end
            ks_if.rk_ready = 1'($urandom_range(0, 1));
            if (ks_if.rk_ready) begin
                if (idx == 10) finished = 1'b1;
                else idx++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL bp_timeout: reached round %0d, required 10 accepted", idx);
        end
        checks++;
        if (ks_if.done !== 1'b1 || ks_if.rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: done=%b valid=%b, required 1 0", ks_if.done, ks_if.rk_valid);
        end
        ks_if.rk_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL bp_done_count: pulses=%0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int d0, n;
        compute_model(128'h0);
        ks_if.rk_ready = 1'b1; ks_if.key_in = to_mat(FIPS_KEY); ks_if.load = 1'b1;
        @(negedge clk);
        ks_if.load = 1'b0;
        n = 0;
        while (ks_if.rk_round !== 4'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ks_if.rk_round !== 4'd4) begin
            errors++;
            $display("FAIL abort_reach4: round=%0d required 4", ks_if.rk_round);
        end
        d0 = done_cnt;
        ks_if.key_in = '0; ks_if.load = 1'b1;
        @(negedge clk);
        ks_if.load = 1'b0;
        checks++;
        if (ks_if.rk_round !== 4'd0 || ks_if.rk !== mat_t'(0) || ks_if.rk_valid !== 1'b1 || ks_if.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: round=%0d rk=%h valid=%b done=%b, required 0 0 1 0",
                     ks_if.rk_round, ks_if.rk, ks_if.rk_valid, ks_if.done);
        end
        @(negedge clk);
        checks++;
        if (ks_if.rk_round !== 4'd1 || ks_if.rk !== to_mat(ZERO_R1)) begin
            errors++;
            $display("FAIL abort_zero_r1: round=%0d rk=%h required 1 %h", ks_if.rk_round, ks_if.rk, to_mat(ZERO_R1));
        end
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (ks_if.rk_round !== 4'(i) || ks_if.rk !== to_mat(model_rk[i]) || ks_if.done !== 1'b0) begin
                errors++;
                $display("FAIL abort_zero_round%0d: round=%0d rk=%h done=%b required %h",
                         i, ks_if.rk_round, ks_if.rk, ks_if.done, to_mat(model_rk[i]));
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL abort_done_count: pulses=%0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        ks_if.rk_ready = 1'b1; ks_if.key_in = to_mat(rand_key()); ks_if.load = 1'b1;
        @(negedge clk);
        ks_if.load = 1'b0;
        n = 0;
        while (ks_if.rk_round !== 4'd6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ks_if.rk_round !== 4'd6) begin
            errors++;
            $display("FAIL rst_reach6: round=%0d required 6", ks_if.rk_round);
        end
        rst = 1'b1; ks_if.load = 1'b1; ks_if.key_in = to_mat(rand_key());
        @(negedge clk);
        rst = 1'b0; ks_if.load = 1'b0;
        checks++;
        if (ks_if.rk !== mat_t'(0) || ks_if.rk_round !== 4'd0 || ks_if.rk_valid !== 1'b0 ||
            ks_if.busy !== 1'b0 || ks_if.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: rk=%h round=%0d valid=%b busy=%b done=%b, required all zero",
                     ks_if.rk, ks_if.rk_round, ks_if.rk_valid, ks_if.busy, ks_if.done);
        end
        @(negedge clk);
        checks++;
        if (ks_if.rk_valid !== 1'b0 || ks_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_load_ignored: valid=%b busy=%b required 0 0", ks_if.rk_valid, ks_if.busy);
        end
    endtask

    initial begin
        ks_if.load = 1'b0; ks_if.rk_ready = 1'b0; ks_if.key_in = '0;
        build_sbox();
        test_reset();
        test_fips();
        test_idle_hold();
`ifdef KEY_SCHED_STORE_EN
        test_store();
`endif
        test_backpressure(FIPS_KEY);
        for (int k = 0; k < 3; k++) test_backpressure(rand_key());
        test_abort();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
